// File: rtl/parallel2serial.sv
// parallel2serial
//   Loads an 8-bit word on a begin strobe and shifts it out LSB-first on a
//   single serial line, one bit per clock. Frame markers flag the first and
//   last bit, and a counter reports how many bits have been presented.
//
// Ports
//   clk             in   1  system clock, rising edge
//   reset           in   1  synchronous active-high reset
//   a               in   8  parallel word, sampled only on the load edge
//   parallel_begin  in   1  load strobe, honoured only while idle
//   d               out  1  serial data bit (registered)
//   serial_start    out  1  high while bit 0 of a frame is on d
//   serial_end      out  1  high while bit 7 of a frame is on d
//   counter         out  4  bits presented so far in the frame (1..8), 0 idle
module parallel2serial (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a,
  input  logic       parallel_begin,
  output logic       d,
  output logic       serial_start,
  output logic       serial_end,
  output logic [3:0] counter
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic       d_reg, d_next;
  logic       start_reg, start_next;
  logic       end_reg, end_next;
  logic [3:0] count_reg, count_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= 8'h00;
      d_reg     <= 1'b0;
      start_reg <= 1'b0;
      end_reg   <= 1'b0;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      d_reg     <= d_next;
      start_reg <= start_next;
      end_reg   <= end_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    d_next     = 1'b0;
    start_next = 1'b0;
    end_next   = 1'b0;
    count_next = 4'd0;

    case (state_reg)
      IDLE: begin
        // Bit 0 goes out on the load edge itself, so the word is visible on
        // d in the very next cycle without an extra pipeline stage.
        if (parallel_begin) begin
          shift_next = a;
          d_next     = a[0];
          start_next = 1'b1;
          count_next = 4'd1;
          state_next = BUSY;
        end
      end

      BUSY: begin
        // The captured word stays put; counter (1..7) doubles as the index
        // of the next bit to present. parallel_begin is ignored here.
        if (count_reg == 4'd8) begin
          state_next = IDLE;
        end else begin
          d_next     = shift_reg[count_reg[2:0]];
          count_next = count_reg + 4'd1;
          end_next   = (count_reg == 4'd7);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign d            = d_reg;
  assign serial_start = start_reg;
  assign serial_end   = end_reg;
  assign counter      = count_reg;

endmodule

// File: tb/tb_parallel2serial.sv
// tb_parallel2serial
//   Directed-vector bench for parallel2serial. Inputs change 1 ns after a
//   rising edge; outputs are sampled at that same point, away from the edge.
module tb_parallel2serial;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a;
  logic       parallel_begin;
  logic       d;
  logic       serial_start;
  logic       serial_end;
  logic [3:0] counter;

  int checks = 0;
  int errors = 0;

  parallel2serial dut (
    .clk            (clk),
    .reset          (reset),
    .a              (a),
    .parallel_begin (parallel_begin),
    .d              (d),
    .serial_start   (serial_start),
    .serial_end     (serial_end),
    .counter        (counter)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " d"},       {7'd0, d},            8'd0);
    check({tag, " start"},   {7'd0, serial_start}, 8'd0);
    check({tag, " end"},     {7'd0, serial_end},   8'd0);
    check({tag, " counter"}, {4'd0, counter},      8'd0);
  endtask

  // Called right after a load edge. Checks the 8 frame cycles against the
  // hand-written word, driving parallel_begin from pb_mask[i] and a from
  // a_mid during cycle i, then checks the idle cycle that follows.
  task automatic expect_frame(input string tag, input logic [7:0] word,
                              input logic [7:0] pb_mask, input logic [7:0] a_mid,
                              input logic pb_after, input logic [7:0] a_after);
    logic [7:0] got_word;
    got_word = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s bit%0d d", tag, i),       {7'd0, d},            {7'd0, word[i]});
      check($sformatf("%s bit%0d start", tag, i),   {7'd0, serial_start}, {7'd0, (i == 0)});
      check($sformatf("%s bit%0d end", tag, i),     {7'd0, serial_end},   {7'd0, (i == 7)});
      check($sformatf("%s bit%0d counter", tag, i), {4'd0, counter},      8'(i + 1));
      got_word[i] = d;
      parallel_begin = pb_mask[i];
      a = a_mid;
      step();
    end
    parallel_begin = pb_after;
    a = a_after;
    check_idle({tag, " idle"});
    $display("frame %s word=%02h serialized=%02h", tag, word, got_word);
  endtask

  initial begin
    reset = 1'b1;
    a = 8'h00;
    parallel_begin = 1'b0;

    // Reset held 12 cycles, with a strobe attempt that reset must override.
    parallel_begin = 1'b1;
    a = 8'hFF;
    repeat (12) step();
    check_idle("in_reset");
    parallel_begin = 1'b0;
    reset = 1'b0;
    step();
    check_idle("after_reset");

    // Basic frame; a changed to 0 mid-frame must not disturb it.
    a = 8'b11010011;
    parallel_begin = 1'b1;
    step();
    expect_frame("d3", 8'b11010011, 8'h00, 8'h00, 1'b0, 8'h00);

    // Strobes at counter==4 (cycle 3) and counter==8 (cycle 7) are ignored.
    a = 8'h6B;
    parallel_begin = 1'b1;
    step();
    expect_frame("repulse", 8'h6B, 8'b1000_1000, 8'h6B, 1'b0, 8'h00);
    step();
    check_idle("repulse idle2");

    // Strobe held high: two frames separated by a single idle cycle.
    a = 8'h3C;
    parallel_begin = 1'b1;
    step();
    expect_frame("held1", 8'h3C, 8'hFF, 8'hC3, 1'b1, 8'hC3);
    step();
    expect_frame("held2", 8'hC3, 8'hFF, 8'h00, 1'b0, 8'h00);

    // Reset at counter==5 aborts the frame.
    a = 8'h96;
    parallel_begin = 1'b1;
    step();
    parallel_begin = 1'b0;
    repeat (4) step();
    check("abort pre counter", {4'd0, counter}, 8'd5);
    check("abort pre d", {7'd0, d}, 8'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("abort");
    step();
    check_idle("abort idle");
    a = 8'hA5;
    parallel_begin = 1'b1;
    step();
    expect_frame("a5", 8'hA5, 8'h00, 8'hA5, 1'b0, 8'h00);

    // Back-to-back loads FF then 01.
    a = 8'hFF;
    parallel_begin = 1'b1;
    step();
    expect_frame("ff", 8'hFF, 8'h00, 8'hFF, 1'b1, 8'h01);
    step();
    expect_frame("01", 8'h01, 8'h00, 8'h00, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
